instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 clrn  in  1  reset, asynchronous, active-low.
REQ-004 imem_req  out  1  instruction-memory read request, level, held until acknowledged.
REQ-005 imem_addr  out  32  word-aligned fetch address, stable while imem_req high.
REQ-006 imem_ack  in  1  one-cycle pulse; imem_rdata valid in the same cycle.
REQ-007 imem_rdata  in  32  fetched instruction word.
REQ-008 redirect  in  1  branch/jump taken; discards all fetched and in-flight instructions.
REQ-009 redirect_pc  in  32  new fetch address; bits [1:0] ignored and treated as 0.
REQ-010 inst_valid  out  1  head instruction available to decode.
REQ-011 dec_ready  in  1  decode accepts the head instruction this cycle.
REQ-012 inst  out  32  head instruction word.
REQ-013 inst_pc  out  32  address of the head instruction.
REQ-014 opcode  out  6  inst[31:26], feeds control-unit opcode.
REQ-015 fun  out  6  inst[5:0], feeds control-unit fun.

Function
REQ-016 States: IDLE (no request outstanding), REQ (request outstanding), DROP (outstanding request whose data is discarded).
REQ-017 2-entry buffer of {pc, inst}; inst_valid = buffer non-empty; outputs driven from the registered head entry, with no combinational path from imem_rdata.
REQ-018 IDLE->REQ when no redirect and (buffer count + 0) < 2; this asserts imem_req with imem_addr = fetch PC.
REQ-019 REQ with imem_ack and no redirect: push {imem_addr, imem_rdata}; fetch PC += 4, wrapping mod 2^32; the next request may be issued in the same cycle if count after push/pop < 2, otherwise go to IDLE.
REQ-020 Occupancy rule: count + outstanding never exceeds 2, so a push never meets a full buffer.
REQ-021 Pop occurs when inst_valid & dec_ready; push and pop in the same cycle leave count unchanged.
REQ-022 Redirect has priority over push, pop and issue: buffer flushed; fetch PC <= {redirect_pc[31:2], 2'b00}; inst_valid low the next cycle.
REQ-023 Redirect in REQ without imem_ack -> DROP; imem_req stays high and imem_addr is unchanged until the ack.
REQ-024 DROP: on imem_ack, data is discarded and the FSM goes to IDLE; a further redirect in DROP updates fetch PC only.
REQ-025 Redirect coinciding with imem_ack: data is discarded; next request uses the redirect address in the following cycle.
REQ-026 Latency: with imem_ack asserted on the first imem_req cycle, inst_valid rises one cycle after the ack; sustained throughput is 1 instruction/cycle with 1-cycle memory.
REQ-027 dec_ready low with a full buffer holds inst, inst_pc and inst_valid stable, with imem_req low.

Reset
REQ-028 clrn low immediately forces: state IDLE, fetch PC = RESET_PC, buffer empty, imem_req 0, imem_addr RESET_PC, inst_valid 0, inst/inst_pc 0.
REQ-029 Reset mid-request abandons the outstanding request; any imem_ack received while clrn is low or in the first cycle after release is ignored.
REQ-030 First imem_req is asserted in the cycle after the first rising edge following clrn release.

Structure
REQ-031 Shared package cpu_pkg holds: XLEN=32, OPCODE_MSB/LSB, FUN_MSB/LSB field positions, default RESET_PC, and the fetch state enum.
REQ-032 One sub-module, fetch_buffer: the 2-entry {pc, inst} FIFO with push, pop and flush, where flush has priority.

Verification
REQ-033 Reset release, RESET_PC=0, 1-cycle ack, dec_ready=1 -> inst_pc sequence 0,4,8,12 on consecutive cycles, and opcode/fun match the words loaded.
REQ-034 dec_ready=0 for 5 cycles -> 2 entries buffered, imem_req low, head held at same pc; dec_ready=1 -> drains in order with no loss and no duplication.
REQ-035 Redirect to 32'h0000_0103 while a request is outstanding with ack delayed 3 cycles -> acked data dropped, next imem_addr=32'h0000_0100, and no stale inst_valid.
REQ-036 Redirect and imem_ack in the same cycle, with buffer holding 1 entry -> buffer empty next cycle, and next request goes to the redirect target.
REQ-037 Fetch PC at 32'hFFFF_FFFC -> following imem_addr 32'h0000_0000.
REQ-038 clrn asserted while imem_req is high, then ack arrives -> ack ignored, and after release the fetch restarts at RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_pkg
//  Purpose  : Shared CPU constants: datapath width, instruction field
//             positions, default reset PC and the fetch state encoding.
//  Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int XLEN       = 32;
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int FUN_MSB    = 5;
    localparam int FUN_LSB    = 0;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // IDLE: nothing outstanding, REQ: request outstanding,
    // DROP: request outstanding whose data will be thrown away
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_buffer
//  Purpose  : Two-entry {pc, inst} FIFO between fetch and decode. Flush has
//             priority over push and pop. Head entry is fully registered.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_buffer
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            clrn,
    input  logic            flush_i,
    input  logic            push_i,
    input  logic [XLEN-1:0] push_pc_i,
    input  logic [XLEN-1:0] push_inst_i,
    input  logic            pop_i,
    output logic            valid_o,
    output logic [1:0]      count_o,
    output logic [XLEN-1:0] head_pc_o,
    output logic [XLEN-1:0] head_inst_o
);

    logic [XLEN-1:0] pc0_q, pc0_d, inst0_q, inst0_d;
    logic [XLEN-1:0] pc1_q, pc1_d, inst1_q, inst1_d;
    logic [1:0]      count_q, count_d;
    logic [1:0]      level;
    logic            do_pop;
    logic            do_push;

    // Next-state: shift head on pop, write incoming word into first free slot
    always_comb begin
        pc0_d   = pc0_q;
        inst0_d = inst0_q;
        pc1_d   = pc1_q;
        inst1_d = inst1_q;
        count_d = count_q;
        do_pop  = pop_i & (count_q != 2'd0);
        level   = count_q - {1'b0, do_pop};
        do_push = push_i & (level != 2'd2);
        if (flush_i) begin
            count_d = 2'd0;
        end else begin
            if (do_pop) begin
                pc0_d   = pc1_q;
                inst0_d = inst1_q;
            end
            if (do_push) begin
                if (level == 2'd0) begin
                    pc0_d   = push_pc_i;
                    inst0_d = push_inst_i;
                end else begin
                    pc1_d   = push_pc_i;
                    inst1_d = push_inst_i;
                end
            end
            count_d = level + {1'b0, do_push};
        end
    end

    // Storage and occupancy registers
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            pc0_q   <= '0;
            inst0_q <= '0;
            pc1_q   <= '0;
            inst1_q <= '0;
            count_q <= 2'd0;
        end else begin
            pc0_q   <= pc0_d;
            inst0_q <= inst0_d;
            pc1_q   <= pc1_d;
            inst1_q <= inst1_d;
            count_q <= count_d;
        end
    end

    assign valid_o     = (count_q != 2'd0);
    assign count_o     = count_q;
    assign head_pc_o   = pc0_q;
    assign head_inst_o = inst0_q;

endmodule
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : instruction_fetch
//  Purpose  : Fetch unit: issues word-aligned reads to instruction memory,
//             buffers up to two fetched words and presents the head to
//             decode. Redirects discard buffered and in-flight words.
//  Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            clrn,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            dec_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    output logic [5:0]      opcode,
    output logic [5:0]      fun
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] redirect_target;
    logic [XLEN-1:0] next_pc;
    logic [1:0]      buf_count;
    logic [1:0]      count_after;
    logic            push, pop, flush;
    logic            redirect_lsbs_unused;

    assign redirect_target      = {redirect_pc[XLEN-1:2], 2'b00};
    assign redirect_lsbs_unused = ^redirect_pc[1:0];
    assign next_pc              = addr_q + 32'd4;

    // Fetch FSM: request issue, acknowledge handling and redirect priority.
    // A new request is only issued when the buffer can absorb its data,
    // so buffered plus outstanding words never exceed two.
    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        addr_d      = addr_q;
        push        = 1'b0;
        flush       = redirect;
        pop         = inst_valid & dec_ready & ~redirect;
        count_after = buf_count - {1'b0, pop} + 2'd1;
        case (state_q)
            IDLE: begin
                if (redirect) begin
                    fetch_pc_d = redirect_target;
                end else if (buf_count < 2'd2) begin
                    state_d = REQ;
                    addr_d  = fetch_pc_q;
                end
            end
            REQ: begin
                if (redirect) begin
                    fetch_pc_d = redirect_target;
                    state_d    = imem_ack ? IDLE : DROP;
                end else if (imem_ack) begin
                    push       = 1'b1;
                    fetch_pc_d = next_pc;
                    if (count_after < 2'd2) begin
                        addr_d = next_pc;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DROP: begin
                if (redirect) begin
                    fetch_pc_d = redirect_target;
                end
                if (imem_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM, fetch PC and request address registers
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
        end
    end

    fetch_buffer u_fetch_buffer (
        .clk         (clk),
        .clrn        (clrn),
        .flush_i     (flush),
        .push_i      (push),
        .push_pc_i   (addr_q),
        .push_inst_i (imem_rdata),
        .pop_i       (pop),
        .valid_o     (inst_valid),
        .count_o     (buf_count),
        .head_pc_o   (inst_pc),
        .head_inst_o (inst)
    );

    assign imem_req  = (state_q != IDLE);
    assign imem_addr = addr_q;
    assign opcode    = inst[OPCODE_MSB:OPCODE_LSB];
    assign fun       = inst[FUN_MSB:FUN_LSB];

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_instruction_fetch
//  Purpose  : Self-checking bench for instruction_fetch with a memory
//             responder and an expected-PC scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        clrn = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        inst_valid;
    logic        dec_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [5:0]  opcode;
    logic [5:0]  fun;

    int checks = 0;
    int errors = 0;

    // memory responder controls
    int ack_delay   = 0;
    bit mem_en      = 1'b0;
    int inject_req  = 0;
    int inject_done = 0;
    int wait_cnt    = 0;

    // scoreboard
    logic [31:0] exp_q[$];
    int          cons_cycle[$];
    int          cons_count = 0;
    int          cycle = 0;
    logic [31:0] m_pc;
    logic [31:0] m_word;

    instruction_fetch #(.RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .clrn        (clrn),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst_valid  (inst_valid),
        .dec_ready   (dec_ready),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .opcode      (opcode),
        .fun         (fun)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    // Memory: acks after ack_delay idle cycles; can inject stray acks
    initial begin
        forever begin
            @(negedge clk);
            imem_ack = 1'b0;
            if (inject_req != inject_done) begin
                imem_ack    = 1'b1;
                imem_rdata  = 32'hDEAD_BEEF;
                inject_done = inject_done + 1;
                wait_cnt    = 0;
            end else if (clrn && mem_en && imem_req) begin
                if (wait_cnt >= ack_delay) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mem_word(imem_addr);
                    wait_cnt   = 0;
                end else begin
                    wait_cnt = wait_cnt + 1;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Scoreboard: every instruction taken by decode is matched against
    // the next expected PC and the word the memory holds there
    initial begin
        forever begin
            @(negedge clk);
            #3;
            cycle = cycle + 1;
            if (clrn && !redirect && inst_valid && dec_ready) begin
                cons_count = cons_count + 1;
                cons_cycle.push_back(cycle);
                checks = checks + 1;
                if (exp_q.size() == 0) begin
                    errors = errors + 1;
                    $display("FAIL unexpected_inst: got pc %h, required no instruction", inst_pc);
                end else begin
                    m_pc   = exp_q.pop_front();
                    m_word = mem_word(m_pc);
                    if (inst_pc !== m_pc) begin
                        errors = errors + 1;
                        $display("FAIL inst_pc: got %h, required %h", inst_pc, m_pc);
                    end
                    checks = checks + 1;
                    if (inst !== m_word || opcode !== m_word[31:26] || fun !== m_word[5:0]) begin
                        errors = errors + 1;
                        $display("FAIL inst_word: got inst %h opcode %h fun %h, required %h %h %h",
                                 inst, opcode, fun, m_word, m_word[31:26], m_word[5:0]);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic apply_reset();
        tick();
        clrn        = 1'b0;
        dec_ready   = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        mem_en      = 1'b0;
        repeat (2) tick();
        exp_q.delete();
        cons_cycle.delete();
    endtask

    task automatic wait_cons(input int target, input int budget, output bit ok);
        int n;
        n = 0;
        while (cons_count < target && n < budget) begin
            tick();
            n++;
        end
        ok = (cons_count >= target);
    endtask

    task automatic test_reset();
        #1 clrn = 1'b0;
        repeat (2) tick();
        checks++;
        if (imem_req !== 1'b0 || imem_addr !== RST_PC) begin
            errors++;
            $display("FAIL reset_req: got req %b addr %h, required 0 %h", imem_req, imem_addr, RST_PC);
        end
        checks++;
        if (inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== 32'h0) begin
            errors++;
            $display("FAIL reset_buf: got valid %b inst %h pc %h, required 0 0 0", inst_valid, inst, inst_pc);
        end
        clrn = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_req: got %b, required 0", imem_req);
        end
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin
            errors++;
            $display("FAIL first_req: got req %b addr %h, required 1 %h", imem_req, imem_addr, RST_PC);
        end
    endtask

    task automatic test_stream();
        int base;
        int rel;
        bit ok;
        apply_reset();
        mem_en    = 1'b1;
        ack_delay = 0;
        dec_ready = 1'b1;
        exp_q     = '{32'h0, 32'h4, 32'h8, 32'hC};
        base      = cons_count;
        rel       = cycle;
        clrn      = 1'b1;
        wait_cons(base + 4, 30, ok);
        dec_ready = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL stream_timeout: consumed %0d, required %0d", cons_count - base, 4);
        end
        checks++;
        if (cons_cycle.size() < 4 || cons_cycle[3] - cons_cycle[0] != 3 || cons_cycle[0] != rel + 3) begin
            errors++;
            $display("FAIL stream_timing: got first %0d span %0d, required first %0d span 3",
                     cons_cycle.size() > 0 ? cons_cycle[0] : -1,
                     cons_cycle.size() >= 4 ? cons_cycle[3] - cons_cycle[0] : -1, rel + 3);
        end
    endtask

    task automatic test_backpressure();
        int base;
        bit ok;
        apply_reset();
        mem_en    = 1'b1;
        ack_delay = 0;
        dec_ready = 1'b0;
        clrn      = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (i >= 3) begin
                checks++;
                if (inst_valid !== 1'b1 || imem_req !== 1'b0 || inst_pc !== 32'h0) begin
                    errors++;
                    $display("FAIL hold_full: got valid %b req %b pc %h, required 1 0 00000000",
                             inst_valid, imem_req, inst_pc);
                end
            end
        end
        mem_en    = 1'b0;
        dec_ready = 1'b1;
        exp_q     = '{32'h0, 32'h4};
        base      = cons_count;
        wait_cons(base + 2, 10, ok);
        checks++;
        if (!ok || inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h8) begin
            errors++;
            $display("FAIL drain_two: got ok %b valid %b req %b addr %h, required 1 0 1 00000008",
                     ok, inst_valid, imem_req, imem_addr);
        end
        mem_en = 1'b1;
        exp_q  = '{32'h8, 32'hC, 32'h10};
        wait_cons(base + 5, 20, ok);
        dec_ready = 1'b0;
        checks++;
        if (!ok || exp_q.size() != 0) begin
            errors++;
            $display("FAIL resume: got ok %b pending %0d, required 1 0", ok, exp_q.size());
        end
    endtask

    task automatic test_redirect_drop();
        int base;
        int n;
        bit ok;
        bit stale;
        apply_reset();
        mem_en    = 1'b1;
        ack_delay = 3;
        dec_ready = 1'b1;
        clrn      = 1'b1;
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL drop_first_req: got req %b addr %h, required 1 00000000", imem_req, imem_addr);
        end
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        exp_q       = '{32'h100, 32'h104};
        base        = cons_count;
        tick();
        redirect = 1'b0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL drop_hold: got req %b addr %h, required 1 00000000", imem_req, imem_addr);
        end
        n     = 0;
        stale = 1'b0;
        while (!(imem_req === 1'b1 && imem_addr !== 32'h0) && n < 15) begin
            if (inst_valid !== 1'b0) stale = 1'b1;
            tick();
            n++;
        end
        checks++;
        if (imem_addr !== 32'h100 || imem_req !== 1'b1) begin
            errors++;
            $display("FAIL drop_target: got req %b addr %h, required 1 00000100", imem_req, imem_addr);
        end
        checks++;
        if (stale) begin
            errors++;
            $display("FAIL drop_stale_valid: got valid 1 before target fetch, required 0");
        end
        wait_cons(base + 2, 30, ok);
        dec_ready = 1'b0;
        checks++;
        if (!ok || exp_q.size() != 0) begin
            errors++;
            $display("FAIL drop_consume: got ok %b pending %0d, required 1 0", ok, exp_q.size());
        end
    endtask

    task automatic test_redirect_ack();
        int base;
        int n;
        bit ok;
        apply_reset();
        mem_en    = 1'b1;
        ack_delay = 2;
        dec_ready = 1'b0;
        clrn      = 1'b1;
        n = 0;
        while (!(imem_ack === 1'b1 && inst_valid === 1'b1) && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (imem_ack !== 1'b1 || inst_valid !== 1'b1 || inst_pc !== 32'h0 || imem_addr !== 32'h4) begin
            errors++;
            $display("FAIL rack_setup: got ack %b valid %b pc %h addr %h, required 1 1 00000000 00000004",
                     imem_ack, inst_valid, inst_pc, imem_addr);
        end
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        tick();
        redirect = 1'b0;
        checks++;
        if (inst_valid !== 1'b0 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL rack_flush: got valid %b req %b, required 0 0", inst_valid, imem_req);
        end
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin
            errors++;
            $display("FAIL rack_target: got req %b addr %h, required 1 00000200", imem_req, imem_addr);
        end
        ack_delay = 0;
        dec_ready = 1'b1;
        exp_q     = '{32'h200, 32'h204};
        base      = cons_count;
        wait_cons(base + 2, 20, ok);
        dec_ready = 1'b0;
        checks++;
        if (!ok || exp_q.size() != 0) begin
            errors++;
            $display("FAIL rack_consume: got ok %b pending %0d, required 1 0", ok, exp_q.size());
        end
    endtask

    task automatic test_wrap();
        int base;
        bit ok;
        apply_reset();
        mem_en      = 1'b1;
        ack_delay   = 0;
        dec_ready   = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        exp_q       = '{32'hFFFF_FFFC, 32'h0, 32'h4};
        base        = cons_count;
        clrn        = 1'b1;
        tick();
        redirect = 1'b0;
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_top: got req %b addr %h, required 1 fffffffc", imem_req, imem_addr);
        end
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL wrap_next: got req %b addr %h, required 1 00000000", imem_req, imem_addr);
        end
        wait_cons(base + 3, 20, ok);
        dec_ready = 1'b0;
        checks++;
        if (!ok || exp_q.size() != 0) begin
            errors++;
            $display("FAIL wrap_consume: got ok %b pending %0d, required 1 0", ok, exp_q.size());
        end
    endtask

    task automatic test_reset_midreq();
        int base;
        bit ok;
        apply_reset();
        mem_en    = 1'b1;
        ack_delay = 3;
        dec_ready = 1'b1;
        clrn      = 1'b1;
        tick();
        tick();
        checks++;
        if (imem_req !== 1'b1) begin
            errors++;
            $display("FAIL midreq_pending: got req %b, required 1", imem_req);
        end
        clrn = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0 || imem_addr !== RST_PC || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got req %b addr %h valid %b, required 0 %h 0",
                     imem_req, imem_addr, inst_valid, RST_PC);
        end
        inject_req = inject_req + 1;
        tick();
        inject_req = inject_req + 1;
        tick();
        ack_delay = 0;
        exp_q     = '{32'h0, 32'h4, 32'h8};
        base      = cons_count;
        clrn      = 1'b1;
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== RST_PC || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreq_restart: got req %b addr %h valid %b, required 1 %h 0",
                     imem_req, imem_addr, inst_valid, RST_PC);
        end
        wait_cons(base + 3, 20, ok);
        dec_ready = 1'b0;
        checks++;
        if (!ok || exp_q.size() != 0) begin
            errors++;
            $display("FAIL midreq_consume: got ok %b pending %0d, required 1 0", ok, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_drop();
        test_redirect_ack();
        test_wrap();
        test_reset_midreq();
        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
